// File: rtl/cle_pkg.sv
// cle_pkg: shared widths and state encoding for the CLE label SRAM scheduler.
package cle_pkg;
   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 1024;
   typedef enum logic {CLEAR, ARB} state_t;
endpackage

// File: rtl/cle_clear_seq.sv
// cle_clear_seq: zero-sweep address counter with a sticky done flag.
module cle_clear_seq import cle_pkg::*; (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last,
   output logic              o_done
);
   logic [ADDR_W-1:0] r_addr;
   logic              r_done;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_addr <= '0;
         r_done <= 1'b0;
      end else if (i_en) begin
         r_addr <= r_addr + 1'b1;
         r_done <= r_done | o_last;
      end
   assign o_addr = r_addr;
   assign o_last = r_addr == ADDR_W'(MEM_DEPTH - 1);
   assign o_done = r_done;
endmodule

// File: rtl/cle_sram_sched.sv
// cle_sram_sched: single-port label SRAM arbiter (write priority, starvation-guarded reads).
// Define CLE_SRAM_CLEAR_EN to zero-sweep the SRAM after reset before opening the ports.
module cle_sram_sched import cle_pkg::*; #(
   parameter logic [3:0] STARVE_MAX = 4'd4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_q,
   output logic              clear_done
);
   state_t            r_state, w_next;
   logic [3:0]        r_starve;
   logic              r_rd1, r_rd2, r_rsp_valid, r_mem_wen;
   logic [DATA_W-1:0] r_rsp_data, r_mem_d;
   logic [ADDR_W-1:0] r_mem_a, w_sweep_addr;
   logic              w_in_arb, w_clearing, w_force_r, w_w_acc, w_r_acc;
   logic              w_sweep_last, w_clear_done;

`ifdef CLE_SRAM_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
   cle_clear_seq u_clear (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_clearing),
      .o_addr (w_sweep_addr),
      .o_last (w_sweep_last),
      .o_done (w_clear_done)
   );
`else
   localparam state_t RST_STATE = ARB;
   assign w_sweep_addr = '0;
   assign w_sweep_last = 1'b0;
   assign w_clear_done = 1'b1;
`endif

   always_comb begin
      w_in_arb   = r_state == ARB;
      w_clearing = r_state == CLEAR;
      w_force_r  = w_in_arb && r_valid && r_starve == STARVE_MAX;
      w_ready    = w_in_arb && !w_force_r;
      r_ready    = w_in_arb && (!w_valid || w_force_r);
      w_w_acc    = w_valid && w_ready;
      w_r_acc    = r_valid && r_ready;
      w_next     = (w_clearing && w_sweep_last) ? ARB : r_state;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= RST_STATE;
      else       r_state <= w_next;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_mem_a     <= '0;
         r_mem_d     <= '0;
         r_mem_wen   <= 1'b1;
         r_rd1       <= 1'b0;
         r_rd2       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_starve    <= '0;
      end else begin
         r_mem_a     <= w_clearing ? w_sweep_addr : w_w_acc ? w_addr : w_r_acc ? r_addr : r_mem_a;
         r_mem_d     <= w_clearing ? '0 : w_w_acc ? w_data : r_mem_d;
         r_mem_wen   <= !(w_clearing || w_w_acc);
         // Read return: SRAM samples mem_a one edge later, q is captured the edge after that
         r_rd1       <= w_r_acc;
         r_rd2       <= r_rd1;
         r_rsp_valid <= r_rd2;
         if (r_rd2) r_rsp_data <= mem_q;
         r_starve    <= (w_in_arb && r_valid && !r_ready) ?
                        ((r_starve == STARVE_MAX) ? r_starve : r_starve + 1'b1) : '0;
      end

   assign mem_a      = r_mem_a;
   assign mem_d      = r_mem_d;
   assign mem_wen    = r_mem_wen;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign clear_done = w_clear_done;
endmodule

// File: tb/tb_cle_sram_sched.sv
// tb_cle_sram_sched: vector table for grants plus a read scoreboard against an SRAM model.
module tb_cle_sram_sched;
   import cle_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        w_valid = 1'b0, r_valid = 1'b0;
   logic [9:0]  w_addr = '0, r_addr = '0;
   logic [7:0]  w_data = '0;
   logic        w_ready, r_ready, rsp_valid, mem_wen, clear_done;
   logic [7:0]  rsp_data, mem_d, mem_q;
   logic [9:0]  mem_a;

   always #5 clk = ~clk;

   cle_sram_sched #(.STARVE_MAX(4'd4)) dut (
      .clk        (clk),
      .reset      (reset),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .r_addr     (r_addr),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .mem_a      (mem_a),
      .mem_d      (mem_d),
      .mem_wen    (mem_wen),
      .mem_q      (mem_q),
      .clear_done (clear_done)
   );

   logic [7:0] sram [1024];
   logic [7:0] model [1024];

   always @(posedge clk) begin
      if (!mem_wen) sram[mem_a] <= mem_d;
      mem_q <= sram[mem_a];
   end

   typedef struct {logic [7:0] d; int due;} exp_t;
   exp_t exp_q[$];
   int cyc = 0, n_chk = 0, n_fail = 0, n_rsp = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) exp_q.delete();
      else begin
         if (w_valid && w_ready) model[w_addr] <= w_data;
         if (r_valid && r_ready) exp_q.push_back('{model[r_addr], cyc + 3});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (rsp_valid) begin
         exp_t e;
         n_rsp++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: got rsp_data %0h with nothing outstanding", rsp_data);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e.d);
            check("rsp_cycle", cyc, e.due);
         end
      end

   typedef struct {
      logic       wv;
      logic [9:0] wa;
      logic [7:0] wd;
      logic       rv;
      logic [9:0] ra;
      logic       ew, er, ewen;
   } vec_t;
   vec_t vt[24];

   initial begin
      vt[0]  = '{1'b1, 10'h21F, 8'h05, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1};
      vt[1]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h21F, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1};
      vt[3]  = '{1'b1, 10'h000, 8'h10, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1};
      vt[4]  = '{1'b1, 10'h001, 8'h11, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
      vt[5]  = '{1'b1, 10'h002, 8'h12, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
      vt[6]  = '{1'b1, 10'h003, 8'h13, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0};
      vt[7]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h000, 1'b1, 1'b1, 1'b0};
      vt[8]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h001, 1'b1, 1'b1, 1'b1};
      vt[9]  = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h002, 1'b1, 1'b1, 1'b1};
      vt[10] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h003, 1'b1, 1'b1, 1'b1};
      vt[11] = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1};
      // Both ports busy: four writes granted, then the starved read is forced through
      for (int k = 0; k < 10; k++) begin
         int j;
         j = (k < 5) ? k : k - 1;
         vt[12 + k] = '{1'b1, 10'(10'h100 + j), 8'(8'h20 + j), 1'b1, 10'h21F,
                        (k % 5) != 4, (k % 5) == 4, (k == 0 || k == 5)};
      end
      vt[22] = '{1'b0, 10'h000, 8'h00, 1'b1, 10'h104, 1'b1, 1'b1, 1'b1};
      vt[23] = '{1'b0, 10'h000, 8'h00, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check("rst_mem_wen", mem_wen, 1);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_d", mem_d, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
`ifdef CLE_SRAM_CLEAR_EN
      check("rst_clear_done", clear_done, 0);
      check("rst_w_ready", w_ready, 0);
      reset = 1'b0;
      for (int k = 0; k < 2000 && mem_a != 10'd500; k++) @(negedge clk);
      check("sweep_reach_500", mem_a, 500);
      #2 reset = 1'b1;
      #1;
      check("midsweep_rst_wen", mem_wen, 1);
      check("midsweep_rst_addr", mem_a, 0);
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         logic l;
         @(negedge clk);
         l = (i == 1023);
         check("sweep", {mem_a, mem_d, mem_wen, w_ready, r_ready, clear_done},
               {10'(i), 8'h00, 1'b0, l, l, l});
      end
`else
      check("rst_clear_done", clear_done, 1);
      @(negedge clk) reset = 1'b0;
      #1;
      check("first_cycle_clear_done", clear_done, 1);
      check("first_cycle_w_ready", w_ready, 1);
`endif

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         w_valid = vt[i].wv;
         w_addr  = vt[i].wa;
         w_data  = vt[i].wd;
         r_valid = vt[i].rv;
         r_addr  = vt[i].ra;
         #1;
         check($sformatf("vec%0d_w_ready", i), w_ready, vt[i].ew);
         check($sformatf("vec%0d_r_ready", i), r_ready, vt[i].er);
         check($sformatf("vec%0d_mem_wen", i), mem_wen, vt[i].ewen);
      end

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      check("rsp_count", n_rsp, 8);

      // An in-flight read is dropped by reset
      @(negedge clk);
      r_valid = 1'b1;
      r_addr  = 10'h000;
      @(negedge clk);
      r_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("inflight_rst_rsp_valid", rsp_valid, 0);
      @(negedge clk) reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check("inflight_dropped", rsp_valid, 0);
      end
      check("rsp_count_after_rst", n_rsp, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
